// File: rtl/seven_seg_scan_n_if.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_n_if
//
// Write-only register bus used to program the seven_seg_scan_n display
// controller. Writes are single-cycle: the slave samples all three signals on
// the rising clock edge. There is no read-back and no wait state.
//
// Signals
//   BUS_WE   : write strobe, one cycle per write
//   BUS_ADDR : 8-bit byte address
//   BUS_DATA : 8-bit write data
//
// Modports
//   master : bus driver (CPU side / testbench)
//   slave  : display controller
// ----------------------------------------------------------------------------
interface seven_seg_scan_n_if;

  logic       BUS_WE;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA;

  modport master (
    output BUS_WE,
    output BUS_ADDR,
    output BUS_DATA
  );

  modport slave (
    input BUS_WE,
    input BUS_ADDR,
    input BUS_DATA
  );

endinterface

// File: rtl/seven_seg_scan_n.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_n
//
// Multiplexed seven-segment display controller with a small register window.
// Each digit is shown for 16 scan ticks. Within that slot the digit is lit
// only while the sub-slot count is at or below the brightness value. This
// gives a 16-step PWM from 1/16 duty (B=0) to full duty (B=15).
//
// Register window (relative to BASE_ADDR)
//   +0 .. +NUM_DIGITS-1 : digit registers
//                         [3:0] hex value, [4] DP on, [5] blank
//   +NUM_DIGITS .. +7   : unmapped; writes are ignored
//   +8                  : CTRL, [3:0] brightness, [7] display enable
//
// Parameters
//   NUM_DIGITS : number of multiplexed digits, 1..8
//   BASE_ADDR  : bus address of digit register 0
//   TICK_DIV   : clock cycles per scan tick, 2..4095
//
// Ports
//   CLK   : single clock, rising edge
//   RESET : asynchronous, active-high reset
//   bus   : register write bus (slave side)
//   SEL   : active-low digit enables, bit i selects digit i (registered)
//   DIGIT : active-low segments, [6:0] = g..a, [7] = decimal point (registered)
// ----------------------------------------------------------------------------
module seven_seg_scan_n #(
  parameter int         NUM_DIGITS = 4,
  parameter logic [7:0] BASE_ADDR  = 8'hD0,
  parameter int         TICK_DIV   = 2500
) (
  input  logic                  CLK,
  input  logic                  RESET,
  seven_seg_scan_n_if.slave     bus,
  output logic [NUM_DIGITS-1:0] SEL,
  output logic [7:0]            DIGIT
);

  // The index register keeps at least one bit so that the single-digit
  // build still has a legal vector. In that build the index is tied at 0.
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(TICK_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]       NUM_DIG8 = 8'(NUM_DIGITS);
  localparam logic [7:0]       CTRL_OFF = 8'd8;

  // Values loaded by reset: every digit blanked, enable on, full brightness.
  localparam logic [5:0]       DIG_RST  = 6'h20;
  localparam logic [3:0]       BRI_RST  = 4'hF;

  // --------------------------------------------------------------------------
  // Hex value to active-low segment pattern, bit order g..a.
  // Letters A-F are shown as A b C d E F.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'b100_0000;
      4'h1:    hex_to_seg = 7'b111_1001;
      4'h2:    hex_to_seg = 7'b010_0100;
      4'h3:    hex_to_seg = 7'b011_0000;
      4'h4:    hex_to_seg = 7'b001_1001;
      4'h5:    hex_to_seg = 7'b001_0010;
      4'h6:    hex_to_seg = 7'b000_0010;
      4'h7:    hex_to_seg = 7'b111_1000;
      4'h8:    hex_to_seg = 7'b000_0000;
      4'h9:    hex_to_seg = 7'b001_0000;
      4'hA:    hex_to_seg = 7'b000_1000;
      4'hB:    hex_to_seg = 7'b000_0011;
      4'hC:    hex_to_seg = 7'b100_0110;
      4'hD:    hex_to_seg = 7'b010_0001;
      4'hE:    hex_to_seg = 7'b000_0110;
      default: hex_to_seg = 7'b000_1110;
    endcase
  endfunction

  // ==========================================================================
  // Stage p0: register window and scan counters
  // ==========================================================================

  // Address offset into the window. The subtraction wraps modulo 256, so
  // addresses below BASE_ADDR land far outside the window and are ignored.
  logic [7:0] addr_off;
  logic       dig_wr;
  logic       ctrl_wr;

  assign addr_off = bus.BUS_ADDR - BASE_ADDR;
  assign dig_wr   = bus.BUS_WE && (addr_off < NUM_DIG8);
  assign ctrl_wr  = bus.BUS_WE && (addr_off == CTRL_OFF);

  // BUS_DATA[6] has no meaning in any register.
  logic unused_data_bit;
  assign unused_data_bit = bus.BUS_DATA[6];

  logic [5:0] dig_reg [NUM_DIGITS];
  logic [3:0] bright;
  logic       disp_en;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_reg[i] <= DIG_RST;
      end
      bright  <= BRI_RST;
      disp_en <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_wr && (addr_off == 8'(i))) begin
          dig_reg[i] <= bus.BUS_DATA[5:0];
        end
      end
      if (ctrl_wr) begin
        bright  <= bus.BUS_DATA[3:0];
        disp_en <= bus.BUS_DATA[7];
      end
    end
  end

  // The prescaler issues a one-cycle tick enable on its terminal count.
  // The sub-slot and digit index move only on that enable, so the whole
  // design stays on the single clock.
  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [3:0]       sub_slot;
  logic [IDX_W-1:0] dig_idx;
  logic [IDX_W-1:0] idx_next;

  assign tick     = (presc == PRE_LAST);
  assign idx_next = (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc    <= '0;
      sub_slot <= '0;
      dig_idx  <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        sub_slot <= sub_slot + 4'd1;
        if (sub_slot == 4'hF) begin
          dig_idx <= idx_next;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Select the current digit register. An explicit compare loop is used
  // instead of a variable array index. When NUM_DIGITS is not a power of two,
  // the index vector can encode values past the last digit, and the loop
  // never reads outside the array.
  // --------------------------------------------------------------------------
  logic [5:0] cur_reg;

  always_comb begin
    cur_reg = dig_reg[0];
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (dig_idx == IDX_W'(i)) begin
        cur_reg = dig_reg[i];
      end
    end
  end

  // The digit is lit when the display is enabled, the PWM window is open,
  // and the digit is not blanked.
  logic                  lit;
  logic [NUM_DIGITS-1:0] sel_d;
  logic [7:0]            digit_d;

  assign lit = disp_en && (sub_slot <= bright) && !cur_reg[5];

  always_comb begin
    sel_d   = '1;
    digit_d = 8'hFF;
    if (lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_idx == IDX_W'(i)) begin
          sel_d[i] = 1'b0;
        end
      end
      digit_d = {~cur_reg[4], hex_to_seg(cur_reg[3:0])};
    end
  end

  // ==========================================================================
  // Stage p1: output registers
  // SEL and DIGIT load on the same edge from the same p0 state. A digit
  // change therefore never shows the old segments on the new digit, and no
  // input reaches an output without passing through a flop.
  // ==========================================================================
  logic [NUM_DIGITS-1:0] sel_p1;
  logic [7:0]            digit_p1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sel_p1   <= '1;
      digit_p1 <= 8'hFF;
    end else begin
      sel_p1   <= sel_d;
      digit_p1 <= digit_d;
    end
  end

  assign SEL   = sel_p1;
  assign DIGIT = digit_p1;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scan_n
//
// Drives one shared register bus into three controllers:
//   - 4 digits, 4 cycles per tick
//   - 1 digit, 3 cycles per tick
//   - 8 digits, 2 cycles per tick
// After every clock edge, SEL and DIGIT of each controller are compared with
// a reference model. The model holds the programmed register contents and
// the number of edges since reset release. From that edge count it derives
// the tick count and then the sub-slot and digit index by integer division.
// ----------------------------------------------------------------------------
module tb_seven_seg_scan_n;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  seven_seg_scan_n_if bus ();

  logic [3:0] sel4;
  logic [0:0] sel1;
  logic [7:0] sel8;
  logic [7:0] dig4, dig1, dig8;

  seven_seg_scan_n #(.NUM_DIGITS(4), .BASE_ADDR(8'hD0), .TICK_DIV(4)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .bus(bus), .SEL(sel4), .DIGIT(dig4)
  );

  seven_seg_scan_n #(.NUM_DIGITS(1), .BASE_ADDR(8'hD0), .TICK_DIV(3)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .bus(bus), .SEL(sel1), .DIGIT(dig1)
  );

  seven_seg_scan_n #(.NUM_DIGITS(8), .BASE_ADDR(8'hD0), .TICK_DIV(2)) u_dut8 (
    .CLK(CLK), .RESET(RESET), .bus(bus), .SEL(sel8), .DIGIT(dig8)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  int         nd [3] = '{4, 1, 8};
  int         td [3] = '{4, 3, 2};
  logic [5:0] dreg [3][8];
  logic [3:0] bri [3];
  logic       en [3];
  int         e;  // edges since reset release

  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) dreg[k][j] = 6'h20;
      bri[k] = 4'hF;
      en[k]  = 1'b1;
    end
    e = 0;
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] off;
    off = addr - 8'hD0;
    for (int k = 0; k < 3; k++) begin
      if (int'(off) < nd[k]) dreg[k][off[2:0]] = data[5:0];
      else if (off == 8'd8) begin
        bri[k] = data[3:0];
        en[k]  = data[7];
      end
    end
  endtask

  function automatic logic [7:0] idle_sel(input int k);
    return 8'((1 << nd[k]) - 1);
  endfunction

  // Outputs expected after the next edge, computed from the state after e edges.
  task automatic predict(input int k, output logic [7:0] s, output logic [7:0] d);
    int ticks, sub, idx;
    logic [5:0] r;
    ticks = e / td[k];
    sub   = ticks % 16;
    idx   = (ticks / 16) % nd[k];
    r     = dreg[k][idx];
    if (en[k] && (sub <= int'(bri[k])) && !r[5]) begin
      s = idle_sel(k) & ~(8'd1 << idx);
      d = {~r[4], SEG[r[3:0]]};
    end else begin
      s = idle_sel(k);
      d = 8'hFF;
    end
  endtask

  // One clock cycle with an optional write, followed by a check of all outputs.
  task automatic cycle(input logic we, input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] es [3];
    logic [7:0] ed [3];
    logic [7:0] gs [3];
    logic [7:0] gd [3];
    bus.BUS_WE   = we;
    bus.BUS_ADDR = addr;
    bus.BUS_DATA = data;
    for (int k = 0; k < 3; k++) begin
      if (RESET) begin
        es[k] = idle_sel(k);
        ed[k] = 8'hFF;
      end else begin
        predict(k, es[k], ed[k]);
      end
    end
    @(posedge CLK);
    if (!RESET) begin
      if (we) model_write(addr, data);
      e++;
    end
    #1;
    cyc++;
    gs[0] = {4'h0, sel4};
    gs[1] = {7'h00, sel1};
    gs[2] = sel8;
    gd[0] = dig4;
    gd[1] = dig1;
    gd[2] = dig8;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("sel_n%0d_cyc%0d", nd[k], cyc), gs[k], es[k]);
      check_val($sformatf("digit_n%0d_cyc%0d", nd[k], cyc), gd[k], ed[k]);
    end
    bus.BUS_WE = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00);
  endtask

  // Assert RESET between clock edges while a write is pending, then confirm
  // that the outputs go idle without waiting for a clock edge.
  task automatic async_reset();
    bus.BUS_WE   = 1'b1;
    bus.BUS_ADDR = 8'hD0;
    bus.BUS_DATA = 8'h07;
    #2;
    RESET = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("async_rst_sel_n%0d", nd[k]),
                (k == 0) ? {4'h0, sel4} : (k == 1) ? {7'h00, sel1} : sel8, idle_sel(k));
      check_val($sformatf("async_rst_digit_n%0d", nd[k]),
                (k == 0) ? dig4 : (k == 1) ? dig1 : dig8, 8'hFF);
    end
    model_reset();
    cycle(1'b1, 8'hD0, 8'h07);  // write under reset, discarded
    cycle(1'b0, 8'h00, 8'h00);
    RESET = 1'b0;
  endtask

  initial begin
    logic [7:0] a, d;
    int         pick;
    bus.BUS_WE   = 1'b0;
    bus.BUS_ADDR = 8'h00;
    bus.BUS_DATA = 8'h00;
    model_reset();

    // Reset state, then blank digits after release.
    idle(2);
    RESET = 1'b0;
    idle(20);

    // Program the digits. The D5 write is unmapped for the 4-digit instance.
    cycle(1'b1, 8'hD0, 8'h01);
    cycle(1'b1, 8'hD1, 8'h12);
    cycle(1'b1, 8'hD2, 8'h03);
    cycle(1'b1, 8'hD3, 8'h1A);
    cycle(1'b1, 8'hD4, 8'h04);
    cycle(1'b1, 8'hD5, 8'h1F);
    cycle(1'b1, 8'hD6, 8'h0C);
    cycle(1'b1, 8'hD7, 8'h15);
    idle(300);

    // Brightness 3: lit for 4 of 16 ticks.
    cycle(1'b1, 8'hD8, 8'h83);
    idle(300);
    cycle(1'b1, 8'hD8, 8'h8F);
    idle(10);

    // Disable mid-slot while the counters keep running, then re-enable.
    cycle(1'b1, 8'hD8, 8'h0F);
    idle(90);
    cycle(1'b1, 8'hD8, 8'h8F);
    idle(100);

    // Write D2 while digit 2 of the 4-digit instance is current.
    for (int i = 0; i < 300 && !((((e / 4) / 16) % 4 == 2) && ((e / 4) % 16 == 5)); i++)
      cycle(1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'hD2, 8'h1E);
    idle(5);
    cycle(1'b1, 8'hD5, 8'h00);
    idle(20);

    // A write that lands on a tick edge.
    for (int i = 0; i < 8 && (e % 4 != 3); i++) cycle(1'b0, 8'h00, 8'h00);
    cycle(1'b1, 8'hD0, 8'h19);
    idle(80);

    // Reset mid-frame: all digits stay blank until they are written again.
    async_reset();
    idle(300);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) async_reset();
      if ($urandom_range(0, 9) < 2) begin
        pick = $urandom_range(0, 11);
        a = (pick < 10) ? 8'(8'hD0 + pick) : 8'($urandom);
        d = 8'($urandom);
        if (a == 8'hD8) d[7] = ($urandom_range(0, 3) != 0);
        else            d[5] = ($urandom_range(0, 3) == 0);
        cycle(1'b1, a, d);
      end else begin
        cycle(1'b0, 8'h00, 8'h00);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_n.md
SEVEN_SEG_SCAN_N -- requirements
Module: seven_seg_scan_n

Interface
REQ-001 The block SHALL expose the parameter NUM_DIGITS, default 4, giving the number of multiplexed digits; legal range is 1..8.
REQ-002 The block SHALL expose the parameter BASE_ADDR, default 8'hD0, giving the first bus address of the register window.
REQ-003 The block SHALL expose the parameter TICK_DIV, default 2500, giving the CLK cycles per scan tick (40 kHz at 100 MHz); legal range is 2..4095.
REQ-004 The port CLK SHALL be an input, 1 bit wide, and is the single clock; all state SHALL be on its rising edge.
REQ-005 The port RESET SHALL be an input, 1 bit wide, and is the reset; it is asynchronous and active-high.
REQ-006 The port BUS_WE SHALL be an input, 1 bit wide, and is the bus write strobe, sampled on the CLK edge.
REQ-007 The port BUS_ADDR SHALL be an input, 8 bits wide, and is the bus address.
REQ-008 The port BUS_DATA SHALL be an input, 8 bits wide, and is the bus write data.
REQ-009 The port SEL SHALL be an output, NUM_DIGITS bits wide, and is the active-low digit enables; bit i drives digit i.
REQ-010 The port DIGIT SHALL be an output, 8 bits wide, and is the active-low segments: [6:0] = g..a, [7] = decimal point.

Function
REQ-011 The register window SHALL decode BASE_ADDR+i (i < NUM_DIGITS) as digit register i: [3:0] hex value, [4] DP on, [5] blank, [7:6] ignored.
REQ-012 The register window SHALL decode BASE_ADDR+8 as CTRL: [3:0] brightness B, [7] display enable; all other bits SHALL be ignored.
REQ-013 A register SHALL update on the CLK edge where BUS_WE=1 and BUS_ADDR matches it; a write to any other address SHALL leave all state unchanged.
REQ-014 Addresses BASE_ADDR+NUM_DIGITS..BASE_ADDR+7 SHALL be unmapped, and writes to them SHALL be ignored.
REQ-015 No clock SHALL be derived: a prescaler counting 0..TICK_DIV-1 SHALL issue a one-cycle tick enable on its terminal count, then wrap to 0.
REQ-016 A 4-bit sub-slot counter SHALL advance on every tick; on its wrap 15->0 the digit index SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-017 When NUM_DIGITS=1 the digit index SHALL stay at 0.
REQ-018 Each digit SHALL therefore be held for 16 ticks, giving a full frame period of 16*NUM_DIGITS*TICK_DIV cycles.
REQ-019 The lit condition SHALL be: enable=1 AND sub-slot <= B AND the current digit's blank bit = 0.
REQ-020 Brightness SHALL follow from REQ-019: B=15 gives 100 % duty and B=0 gives 1/16 duty.
REQ-021 While lit, SEL SHALL hold exactly one bit low (the current index) and DIGIT SHALL carry the standard hex decode of the value with DIGIT[7] = ~DP.
REQ-022 The hex decode SHALL drive DIGIT[6:0] as follows: 0 -> 7'b1000000 (segments g..a), 8 -> 7'b0000000, F -> 7'b0001110, and A-F shown as A b C d E F.
REQ-023 While not lit, SEL SHALL be all ones and DIGIT SHALL be 8'hFF.
REQ-024 SEL and DIGIT SHALL be registered outputs, and no combinational path SHALL run from any input to any output.
REQ-025 Latency: a register write on edge k SHALL be visible on SEL/DIGIT at edge k+1 when the affected digit is current and lit.
REQ-026 Latency: a tick on edge k SHALL be reflected in SEL/DIGIT at edge k+1.
REQ-027 On a change of digit index, the new SEL value and the new DIGIT value SHALL update on the same edge, so that no cycle shows the old segments on the new digit.
REQ-028 A write to the current digit mid-slot SHALL take effect per REQ-025 without resetting the counters.
REQ-029 Clearing the enable SHALL blank the outputs on the next edge, while the prescaler, sub-slot counter and digit index keep running.
REQ-030 A write that coincides with a tick SHALL complete both actions: the register SHALL update and the counters SHALL advance on the same edge.
REQ-031 Synthesised RTL SHALL latch no X and SHALL infer no latches.

Reset
REQ-032 Asserting RESET SHALL immediately, without waiting for CLK, set the prescaler, sub-slot counter and digit index to 0, every digit register to 8'h20 (blanked), and CTRL to 8'h8F.
REQ-033 Asserting RESET SHALL immediately, without waiting for CLK, drive SEL to all ones and DIGIT to 8'hFF.
REQ-034 RESET asserted mid-frame or mid-write SHALL discard the write and restart scanning from digit 0, sub-slot 0, after release.
REQ-035 The first tick after release SHALL occur TICK_DIV cycles after the first active edge.

Verification
REQ-036 Scenario (NUM_DIGITS=4, TICK_DIV=4): write 8'h01,8'h12,8'h03,8'h1A to D0..D3 -> SEL cycles 1110,1101,1011,0111, each held for 64 cycles, with DIGIT F9, 24 (DP on), B0, 08 (DP on).
REQ-037 Scenario: write CTRL=8'h83 -> every digit slot is lit for exactly 4 of 16 ticks (16 cycles), then SEL=all ones, DIGIT=FF for the remaining 48 cycles.
REQ-038 Scenario: write CTRL=8'h0F mid-slot -> SEL=all ones and DIGIT=FF from the next edge, with the counters still advancing; then write 8'h8F -> output resumes at the correct digit index.
REQ-039 Scenario: write to D2 while digit 2 is current -> DIGIT changes exactly one edge after the write edge; a write to BASE_ADDR+5 changes nothing.
REQ-040 Scenario: assert RESET asynchronously between edges mid-frame -> outputs go to SEL=all ones, DIGIT=FF at once; after release, all digits stay blank until written.
REQ-041 Scenario (NUM_DIGITS=1 and NUM_DIGITS=8): check wrap and single-bit SEL at 1-digit/8-digit boundaries; the index never exceeds NUM_DIGITS-1.
